writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back logic, directly downstream of the memory stage.
- Captures memory-stage results each cycle and aligns/extends load data by access size.
- Selects the load or ALU result and drives the register-file write port back into decode (regWrite, writeAddr, writeData).
- Supports stall (hold) and flush (bubble) from hazard control.

Parameters:
DATA_W, 32, datapath and register-file data width
ADDR_W, 5, register-file address width
CNT_W, 32, retire counter width (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
stall  in  1  hold MEM/WB register contents
flush  in  1  load a bubble into MEM/WB register
memValid  in  1  memory stage holds a real instruction
memRegWrite  in  1  instruction writes a register
memMemToReg  in  1  1 = write load data, 0 = write ALU result
memLoadSize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
memLoadUnsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
memByteOffset  in  2  address[1:0] of the load
memReadData  in  DATA_W  raw data-memory read word
memALUResult  in  DATA_W  ALU result from memory stage
memWriteReg  in  ADDR_W  destination register
regWrite  out  1  register-file write enable, to decode
writeAddr  out  ADDR_W  register-file write address, to decode
writeData  out  DATA_W  register-file write data, to decode and forwarding
wbValid  out  1  WB register holds a real instruction
alignErr  out  1  current WB instruction is a misaligned half load
retireCount  out  CNT_W  retired-instruction count (optional feature only)

Behaviour:
- Reset (reset=0, async): all pipeline fields cleared. regWrite=0, writeAddr=0, writeData=0, wbValid=0, alignErr=0, retireCount=0. Outputs stay at these values until the first load after reset deasserts.
- Register update at posedge, priority is flush > stall > load:
  - flush=1: bubble loaded (valid=0, regWrite=0, other fields 0). Flush wins when stall is also 1.
  - stall=1, flush=0: every field holds its value. Outputs are unchanged, so a pending register write is re-asserted each stalled cycle (idempotent).
  - Otherwise: all mem* inputs captured.
- Latency: one cycle. Inputs present at edge N appear on the outputs after edge N.
- regWrite = stored valid & stored regWrite & (stored writeReg != 0). A write to r0 is always suppressed, and writeAddr still shows 0.
- writeAddr = stored writeReg.
- writeData is combinational from registered fields only (no combinational path from mem* inputs):
  - memToReg=0: stored ALU result.
  - memToReg=1, word (00/11): stored read word; offset ignored.
  - half (01): offset[1]=0 selects bits 15:0, offset[1]=1 selects bits 31:16. Extended to DATA_W per the unsigned flag.
  - byte (10): offset selects bits [8*off+7 : 8*off]. Extended per the unsigned flag.
- Load data is little-endian.
- alignErr = stored valid & memToReg & half & offset[0]. Data still uses offset[1] only. alignErr is informational and does not cancel the write.
- wbValid = stored valid.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined:
  - retireCount increments by 1 at each posedge where a load occurs with memValid=1 (stall=0, flush=0).
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined: the retireCount port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
1. Reset: drive reset=0 mid-run with regWrite asserted -> all outputs 0 immediately, without waiting for a clock edge; first valid load after release appears one cycle later.
2. ALU write: memValid=1, memRegWrite=1, memMemToReg=0, memALUResult=0x0000_1234, memWriteReg=7 -> next cycle regWrite=1, writeAddr=7, writeData=0x0000_1234.
3. Byte load: memReadData=0x80FF_7F01, size=10 -> offset=3 signed gives 0xFFFF_FF80; offset=3 unsigned gives 0x0000_0080; offset=1 signed gives 0x0000_007F.
4. Half load: same data, size=01 -> offset=2 signed gives 0xFFFF_80FF with alignErr=0; offset=3 gives the same data with alignErr=1.
5. r0 write: memWriteReg=0, memRegWrite=1 -> regWrite=0, wbValid=1.
6. Hazard control: load entry A, then stall=1 for 2 cycles while inputs change to B -> outputs stay A; then stall=1 and flush=1 together -> bubble with regWrite=0 and wbValid=0. With WB_RETIRE_COUNT_EN defined, retireCount=1.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// MEM/WB pipeline register followed by the write-back mux. Each cycle the
// memory-stage results are captured (or held on stall, or replaced by a bubble
// on flush). Load data is then aligned and extended by access size, and the
// load or ALU result is driven onto the register-file write port. The write
// port feeds decode and the forwarding network.
//
// Optional feature: define WB_RETIRE_COUNT_EN to add the retireCount port and a
// saturating counter of retired (captured, valid) instructions.
//
// Ports:
//   clock            rising-edge system clock
//   reset            asynchronous active-low reset
//   stall            hold all MEM/WB fields
//   flush            load a bubble (wins over stall)
//   memValid         memory stage holds a real instruction
//   memRegWrite      instruction writes a register
//   memMemToReg      1 = load data, 0 = ALU result
//   memLoadSize      00 word, 01 half, 10 byte, 11 word
//   memLoadUnsigned  1 = zero-extend sub-word loads
//   memByteOffset    load address[1:0]
//   memReadData      raw data-memory read word
//   memALUResult     ALU result
//   memWriteReg      destination register
//   regWrite         register-file write enable (never for r0)
//   writeAddr        register-file write address
//   writeData        register-file write data
//   wbValid          WB register holds a real instruction
//   alignErr         misaligned half load in WB (informational only)
//   retireCount      retired-instruction count (WB_RETIRE_COUNT_EN only)
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic              memMemToReg,
  input  logic [1:0]        memLoadSize,
  input  logic              memLoadUnsigned,
  input  logic [1:0]        memByteOffset,
  input  logic [DATA_W-1:0] memReadData,
  input  logic [DATA_W-1:0] memALUResult,
  input  logic [ADDR_W-1:0] memWriteReg,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              wbValid,
  output logic              alignErr
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  retireCount
`endif
);

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  // MEM/WB register fields
  logic              validReg;
  logic              regWriteReg;
  logic              memToRegReg;
  logic [1:0]        loadSizeReg;
  logic              unsignedReg;
  logic [1:0]        offsetReg;
  logic [DATA_W-1:0] readDataReg;
  logic [DATA_W-1:0] aluResultReg;
  logic [ADDR_W-1:0] writeRegReg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      validReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      memToRegReg  <= 1'b0;
      loadSizeReg  <= 2'b00;
      unsignedReg  <= 1'b0;
      offsetReg    <= 2'b00;
      readDataReg  <= '0;
      aluResultReg <= '0;
      writeRegReg  <= '0;
    end else if (flush) begin
      validReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      memToRegReg  <= 1'b0;
      loadSizeReg  <= 2'b00;
      unsignedReg  <= 1'b0;
      offsetReg    <= 2'b00;
      readDataReg  <= '0;
      aluResultReg <= '0;
      writeRegReg  <= '0;
    end else if (!stall) begin
      validReg     <= memValid;
      regWriteReg  <= memRegWrite;
      memToRegReg  <= memMemToReg;
      loadSizeReg  <= memLoadSize;
      unsignedReg  <= memLoadUnsigned;
      offsetReg    <= memByteOffset;
      readDataReg  <= memReadData;
      aluResultReg <= memALUResult;
      writeRegReg  <= memWriteReg;
    end
  end

  // Little-endian byte lanes of the stored read word
  logic [7:0] byteLane [4];
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    assign byteLane[gi] = readDataReg[8*gi +: 8];
  end

  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] byteExt;
  logic [DATA_W-1:0] halfExt;

  // Half selection uses offset[1] only; a set offset[0] is flagged via alignErr.
  always_comb begin
    byteSel = byteLane[offsetReg];
    halfSel = offsetReg[1] ? readDataReg[31:16] : readDataReg[15:0];
    byteExt = {{(DATA_W-8){byteSel[7] & ~unsignedReg}}, byteSel};
    halfExt = {{(DATA_W-16){halfSel[15] & ~unsignedReg}}, halfSel};
  end

  always_comb begin
    writeData = aluResultReg;
    if (memToRegReg) begin
      case (loadSizeReg)
        SIZE_HALF: writeData = halfExt;
        SIZE_BYTE: writeData = byteExt;
        default:   writeData = readDataReg;  // word and reserved encoding
      endcase
    end
  end

  assign regWrite  = validReg & regWriteReg & (writeRegReg != '0);
  assign writeAddr = writeRegReg;
  assign wbValid   = validReg;
  assign alignErr  = validReg & memToRegReg & (loadSizeReg == SIZE_HALF) & offsetReg[0];

`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] retireReg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retireReg <= '0;
    end else if (!flush && !stall && memValid && (retireReg != {CNT_W{1'b1}})) begin
      retireReg <= retireReg + 1'b1;
    end
  end

  assign retireCount = retireReg;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        memValid = 1'b0;
  logic        memRegWrite = 1'b0;
  logic        memMemToReg = 1'b0;
  logic [1:0]  memLoadSize = 2'b00;
  logic        memLoadUnsigned = 1'b0;
  logic [1:0]  memByteOffset = 2'b00;
  logic [31:0] memReadData = '0;
  logic [31:0] memALUResult = '0;
  logic [4:0]  memWriteReg = '0;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        wbValid;
  logic        alignErr;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retireCount;
`endif

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .memValid(memValid), .memRegWrite(memRegWrite), .memMemToReg(memMemToReg),
    .memLoadSize(memLoadSize), .memLoadUnsigned(memLoadUnsigned),
    .memByteOffset(memByteOffset), .memReadData(memReadData),
    .memALUResult(memALUResult), .memWriteReg(memWriteReg),
    .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
    .wbValid(wbValid), .alignErr(alignErr)
`ifdef WB_RETIRE_COUNT_EN
    , .retireCount(retireCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        valid;
    bit        rw;
    bit        m2r;
    bit [1:0]  size;
    bit        uns;
    bit [1:0]  off;
    bit [31:0] rd;
    bit [31:0] alu;
    bit [4:0]  wr;
  } entry_t;

  entry_t model;
  longint modelCount = 0;
  int     nChecks = 0;
  int     nErrors = 0;

  function automatic entry_t bubble();
    entry_t e;
    e.valid = 0; e.rw = 0; e.m2r = 0; e.size = 0; e.uns = 0;
    e.off = 0; e.rd = 0; e.alu = 0; e.wr = 0;
    return e;
  endfunction

  // Reference write data from the architectural load rules (shift/mask/wrap).
  function automatic bit [31:0] expData(entry_t e);
    longint v;
    if (!e.m2r) return e.alu;
    case (e.size)
      2'b01: begin
        v = (longint'(e.rd) >> (e.off[1] ? 16 : 0)) & 'hFFFF;
        if (!e.uns && v >= 32768) v = v - 65536;
      end
      2'b10: begin
        v = (longint'(e.rd) >> (8 * e.off)) & 'hFF;
        if (!e.uns && v >= 128) v = v - 256;
      end
      default: v = longint'(e.rd);
    endcase
    return v[31:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(string tag);
    chk({tag, ".regWrite"},  64'(regWrite),  64'(model.valid && model.rw && model.wr != 0));
    chk({tag, ".writeAddr"}, 64'(writeAddr), 64'(model.wr));
    chk({tag, ".writeData"}, 64'(writeData), 64'(expData(model)));
    chk({tag, ".wbValid"},   64'(wbValid),   64'(model.valid));
    chk({tag, ".alignErr"},  64'(alignErr),
        64'(model.valid && model.m2r && model.size == 2'b01 && model.off[0]));
`ifdef WB_RETIRE_COUNT_EN
    chk({tag, ".retireCount"}, 64'(retireCount), 64'(modelCount));
`endif
    $display("step %-10s rw=%0b addr=%0d data=%h valid=%0b align=%0b",
             tag, regWrite, writeAddr, writeData, wbValid, alignErr);
  endtask

  // One clock edge: advance the model with flush > stall > load, then check.
  task automatic step(string tag);
    @(posedge clock);
    if (flush) begin
      model = bubble();
    end else if (!stall) begin
      model.valid = memValid;   model.rw = memRegWrite; model.m2r = memMemToReg;
      model.size = memLoadSize; model.uns = memLoadUnsigned; model.off = memByteOffset;
      model.rd = memReadData;   model.alu = memALUResult; model.wr = memWriteReg;
      if (memValid && modelCount < 64'hFFFF_FFFF) modelCount++;
    end
    #1;
    checkAll(tag);
    @(negedge clock);
  endtask

  task automatic drive(bit v, bit rw, bit m2r, bit [1:0] sz, bit uns, bit [1:0] off,
                       bit [31:0] rd, bit [31:0] alu, bit [4:0] wr);
    memValid = v; memRegWrite = rw; memMemToReg = m2r; memLoadSize = sz;
    memLoadUnsigned = uns; memByteOffset = off; memReadData = rd;
    memALUResult = alu; memWriteReg = wr;
  endtask

  initial begin
    model = bubble();
    // Reset state
    #1;
    checkAll("reset");
    @(negedge clock);
    reset = 1'b1;

    // ALU write
    drive(1, 1, 0, 2'b00, 0, 2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7);
    step("alu");

    // Byte loads
    drive(1, 1, 1, 2'b10, 0, 2'd3, 32'h80FF_7F01, 32'h0, 5'd3);
    step("byte3s");
    drive(1, 1, 1, 2'b10, 1, 2'd3, 32'h80FF_7F01, 32'h0, 5'd3);
    step("byte3u");
    drive(1, 1, 1, 2'b10, 0, 2'd1, 32'h80FF_7F01, 32'h0, 5'd3);
    step("byte1s");

    // Half loads, aligned and misaligned
    drive(1, 1, 1, 2'b01, 0, 2'd2, 32'h80FF_7F01, 32'h0, 5'd4);
    step("half2");
    drive(1, 1, 1, 2'b01, 0, 2'd3, 32'h80FF_7F01, 32'h0, 5'd4);
    step("half3");

    // Word and reserved size ignore offset
    drive(1, 1, 1, 2'b11, 0, 2'd1, 32'h1357_9BDF, 32'h0, 5'd9);
    step("word11");

    // Write to r0 is suppressed
    drive(1, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'hAAAA_5555, 5'd0);
    step("r0");

    // Asynchronous reset while a write is pending
    drive(1, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0000_00FE, 5'd12);
    step("prerst");
    #2;
    reset = 1'b0;
    model = bubble();
    modelCount = 0;
    #1;
    checkAll("asyncrst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(1, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0000_0A0A, 5'd5);
    step("postrst");

    // Hazard control: A, stall twice with B on inputs, then stall+flush
    drive(1, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'hAAAA_0001, 5'd10);
    step("entryA");
    stall = 1'b1;
    drive(1, 1, 1, 2'b10, 0, 2'd2, 32'h1234_5678, 32'hBBBB_0002, 5'd11);
    step("stall1");
    step("stall2");
    flush = 1'b1;
    step("flush");
    stall = 1'b0;
    flush = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), $urandom_range(0, 1), 2'($urandom), $urandom, $urandom,
            5'($urandom));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    stall = 1'b0;
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
